// File: rtl/issue_dispatcher.sv
// Issue dispatcher: buffers decoded instructions in a small circular queue,
// resolves source operands against RF / RoB / CDB / the previous dispatch,
// and issues at most one instruction per cycle in program order.
module issue_dispatcher #(
  parameter int ROB_WIDTH = 8,
  parameter int CDB_CH    = 2,
  parameter int IQ_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         DCDP_en,
  input  logic [86:0]                  DCDP_inst,
  output logic                         DPDC_ready,
  output logic [11:0]                  DPRF_rs,
  input  logic [2*(ROB_WIDTH+1)-1:0]   RFDP_Q,
  input  logic [63:0]                  RFDP_V,
  output logic                         DPRF_en,
  output logic [5:0]                   DPRF_rd,
  output logic [ROB_WIDTH-1:0]         DPRF_RoB_index,
  input  logic [ROB_WIDTH-1:0]         RoBDP_RoB_index,
  input  logic [1:0]                   RoBDP_ready,
  input  logic [63:0]                  RoBDP_V,
  input  logic                         RoBDP_flush,
  input  logic [CDB_CH-1:0]            CDB_en,
  input  logic [CDB_CH*ROB_WIDTH-1:0]  CDB_RoB_index,
  input  logic [CDB_CH*32-1:0]         CDB_value,
  input  logic                         RS_full,
  input  logic                         LSB_full,
  input  logic                         RoB_full,
  output logic                         DPRoB_en,
  output logic                         DPRS_en,
  output logic                         DPLSB_en,
  output logic [77:0]                  DP_op,
  output logic [63:0]                  DP_V,
  output logic [2*(ROB_WIDTH+1)-1:0]   DP_Q
);

  localparam int QW = ROB_WIDTH + 1;
  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [QW-1:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}};
  localparam logic [5:0]    NON_REG = 6'b100000;

  logic [86:0]   r_q [IQ_DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  logic [86:0]   w_head;
  logic [6:0]    w_opc;
  logic [5:0]    w_rs1, w_rs2, w_rd;
  logic          w_ls, w_push, w_pop;
  logic [QW+31:0] w_res_j, w_res_k;

  function automatic logic is_ls(input logic [6:0] op);
    return (op >= 7'd11) && (op <= 7'd18);
  endfunction

  function automatic logic rs1_unused(input logic [6:0] op);
    return (op >= 7'd1) && (op <= 7'd3);
  endfunction

  function automatic logic rs2_unused(input logic [6:0] op);
    return ((op >= 7'd1) && (op <= 7'd4)) || ((op >= 7'd11) && (op <= 7'd15)) ||
           ((op >= 7'd19) && (op <= 7'd27));
  endfunction

  function automatic logic rd_unused(input logic [6:0] op, input logic [4:0] rd);
    return ((op >= 7'd5) && (op <= 7'd10)) || ((op >= 7'd16) && (op <= 7'd18)) ||
           (rd == 5'd0);
  endfunction

  // The previous dispatch's rename has not reached the RF yet, so it must
  // override even a "ready" RF answer; otherwise RoB, then CDB (channel 0 wins).
  function automatic logic [QW+31:0] resolve(
    input logic [5:0]                  rs,
    input logic [QW-1:0]               rf_q,
    input logic [31:0]                 rf_v,
    input logic                        rob_rdy,
    input logic [31:0]                 rob_v,
    input logic [CDB_CH-1:0]           cdb_en,
    input logic [CDB_CH*ROB_WIDTH-1:0] cdb_idx,
    input logic [CDB_CH*32-1:0]        cdb_val,
    input logic                        fwd_en,
    input logic [5:0]                  fwd_rd,
    input logic [ROB_WIDTH-1:0]        fwd_tag
  );
    logic [QW-1:0] q;
    logic [31:0]   v;
    q = rf_q;
    v = '0;
    if (rs == NON_REG) begin
      q = NON_DEP;
    end else if (fwd_en && (fwd_rd != NON_REG) && (fwd_rd == rs)) begin
      q = {1'b0, fwd_tag};
    end else if (rf_q == NON_DEP) begin
      v = rf_v;
    end else if (rob_rdy) begin
      q = NON_DEP;
      v = rob_v;
    end else begin
      for (int c = CDB_CH - 1; c >= 0; c--) begin
        if (cdb_en[c] && ({1'b0, cdb_idx[c*ROB_WIDTH +: ROB_WIDTH]} == rf_q)) begin
          q = NON_DEP;
          v = cdb_val[c*32 +: 32];
        end
      end
    end
    return {q, v};
  endfunction

  // Head decode, handshakes and operand resolution
  always_comb begin
    w_head  = r_q[r_head];
    w_opc   = w_head[54:48];
    w_rs1   = rs1_unused(w_opc) ? NON_REG : {1'b0, w_head[47:43]};
    w_rs2   = rs2_unused(w_opc) ? NON_REG : {1'b0, w_head[42:38]};
    w_rd    = rd_unused(w_opc, w_head[37:33]) ? NON_REG : {1'b0, w_head[37:33]};
    w_ls    = is_ls(w_opc);
    DPDC_ready = (r_count != CW'(IQ_DEPTH));
    DPRF_rs = {w_rs2, w_rs1};
    w_push  = !rst && rdy && !RoBDP_flush && DCDP_en && DPDC_ready;
    w_pop   = !rst && rdy && !RoBDP_flush && (r_count != '0) && !RoB_full &&
              (w_ls ? !LSB_full : !RS_full);
    w_res_j = resolve(w_rs1, RFDP_Q[QW-1:0], RFDP_V[31:0], RoBDP_ready[0], RoBDP_V[31:0],
                      CDB_en, CDB_RoB_index, CDB_value, DPRF_en, DPRF_rd, DPRF_RoB_index);
    w_res_k = resolve(w_rs2, RFDP_Q[2*QW-1:QW], RFDP_V[63:32], RoBDP_ready[1], RoBDP_V[63:32],
                      CDB_en, CDB_RoB_index, CDB_value, DPRF_en, DPRF_rd, DPRF_RoB_index);
  end

  // Queue storage write
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_tail] <= DCDP_inst;
  end

  // Pointers, count and registered dispatch outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0; r_tail <= '0; r_count <= '0;
      DPRoB_en <= 1'b0; DPRS_en <= 1'b0; DPLSB_en <= 1'b0; DPRF_en <= 1'b0;
      DP_op <= '0; DP_V <= '0; DP_Q <= '0; DPRF_rd <= '0; DPRF_RoB_index <= '0;
    end else if (!rdy) begin
      DPRoB_en <= 1'b0; DPRS_en <= 1'b0; DPLSB_en <= 1'b0; DPRF_en <= 1'b0;
    end else if (RoBDP_flush) begin
      r_head <= '0; r_tail <= '0; r_count <= '0;
      DPRoB_en <= 1'b0; DPRS_en <= 1'b0; DPLSB_en <= 1'b0; DPRF_en <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      DPRoB_en <= w_pop;
      DPRF_en  <= w_pop;
      DPRS_en  <= w_pop && !w_ls;
      DPLSB_en <= w_pop && w_ls;
      if (w_pop) begin
        DP_op          <= {w_head[86:55], w_opc, w_head[32:1], w_rd, w_head[0]};
        DP_V           <= {w_res_k[31:0], w_res_j[31:0]};
        DP_Q           <= {w_res_k[QW+31:32], w_res_j[QW+31:32]};
        DPRF_rd        <= w_rd;
        DPRF_RoB_index <= RoBDP_RoB_index;
      end
    end
  end

endmodule

// File: tb/tb_issue_dispatcher.sv
// Scoreboard bench for issue_dispatcher: expected dispatches are queued when
// instructions are offered and compared when the dispatch pulses appear.
module tb_issue_dispatcher;

  localparam logic [8:0] ND = 9'h100;
  localparam logic [5:0] NR = 6'b100000;

  logic         clk = 1'b0;
  logic         rst, rdy, DCDP_en, DPDC_ready, DPRF_en, RoBDP_flush;
  logic [86:0]  DCDP_inst;
  logic [11:0]  DPRF_rs;
  logic [17:0]  RFDP_Q, DP_Q;
  logic [63:0]  RFDP_V, RoBDP_V, DP_V, CDB_value;
  logic [5:0]   DPRF_rd;
  logic [7:0]   DPRF_RoB_index, RoBDP_RoB_index;
  logic [1:0]   RoBDP_ready, CDB_en;
  logic [15:0]  CDB_RoB_index;
  logic         RS_full, LSB_full, RoB_full, DPRoB_en, DPRS_en, DPLSB_en;
  logic [77:0]  DP_op;

  typedef struct {
    logic [77:0] op;
    logic [63:0] v;
    logic [17:0] q;
    logic [5:0]  rd;
    logic [7:0]  tag;
    logic        lsb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  issue_dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy), .DCDP_en(DCDP_en), .DCDP_inst(DCDP_inst),
    .DPDC_ready(DPDC_ready), .DPRF_rs(DPRF_rs), .RFDP_Q(RFDP_Q), .RFDP_V(RFDP_V),
    .DPRF_en(DPRF_en), .DPRF_rd(DPRF_rd), .DPRF_RoB_index(DPRF_RoB_index),
    .RoBDP_RoB_index(RoBDP_RoB_index), .RoBDP_ready(RoBDP_ready), .RoBDP_V(RoBDP_V),
    .RoBDP_flush(RoBDP_flush), .CDB_en(CDB_en), .CDB_RoB_index(CDB_RoB_index),
    .CDB_value(CDB_value), .RS_full(RS_full), .LSB_full(LSB_full), .RoB_full(RoB_full),
    .DPRoB_en(DPRoB_en), .DPRS_en(DPRS_en), .DPLSB_en(DPLSB_en), .DP_op(DP_op),
    .DP_V(DP_V), .DP_Q(DP_Q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [86:0] mk(input logic [31:0] pc, input logic [6:0] op,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [31:0] imm,
                                     input logic p);
    return {pc, op, rs1, rs2, rd, imm, p};
  endfunction

  function automatic exp_t mkexp(input logic [31:0] pc, input logic [6:0] op,
                                 input logic [31:0] imm, input logic [5:0] rd, input logic p,
                                 input logic [63:0] v, input logic [17:0] q,
                                 input logic [7:0] tag, input logic lsb);
    exp_t e;
    e.op = {pc, op, imm, rd, p};
    e.v = v; e.q = q; e.rd = rd; e.tag = tag; e.lsb = lsb;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [86:0] inst, input bit expect_it, input exp_t e);
    check("push_ready", DPDC_ready, 1'b1);
    DCDP_en = 1'b1;
    DCDP_inst = inst;
    if (expect_it) sb.push_back(e);
    tick(1);
    DCDP_en = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      check(tag, {DPRoB_en, DPRS_en, DPLSB_en, DPRF_en}, 4'b0);
    end
    tick(1);
  endtask

  // Dispatch monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && (DPRoB_en || DPRS_en || DPLSB_en || DPRF_en)) begin
      if (sb.size() == 0) begin
        check("unexpected_dispatch", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rob_rf_en", {DPRoB_en, DPRF_en}, 2'b11);
        check("unit_sel", {DPLSB_en, DPRS_en}, {e.lsb, !e.lsb});
        check("dp_op", DP_op, e.op);
        check("dp_v", DP_V, e.v);
        check("dp_q", DP_Q, e.q);
        check("dprf_rd", DPRF_rd, e.rd);
        check("dprf_tag", DPRF_RoB_index, e.tag);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t none;
    none = mkexp('0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    rst = 1'b1; rdy = 1'b1; DCDP_en = 1'b0; DCDP_inst = '0; RoBDP_flush = 1'b0;
    RFDP_Q = {ND, ND}; RFDP_V = '0; RoBDP_RoB_index = '0; RoBDP_ready = '0;
    RoBDP_V = '0; CDB_en = '0; CDB_RoB_index = '0; CDB_value = '0;
    RS_full = 1'b0; LSB_full = 1'b0; RoB_full = 1'b0;
    tick(2);
    @(negedge clk);
    check("rst_en", {DPRoB_en, DPRS_en, DPLSB_en, DPRF_en}, 4'b0);
    check("rst_ready", DPDC_ready, 1'b1);
    check("rst_op", DP_op, 78'b0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // addi x5,x1,4 with a ready RF operand; two-cycle latency
    RFDP_V = {32'd99, 32'd10}; RoBDP_RoB_index = 8'd1;
    push_inst(mk(32'h1000, 7'd19, 5'd1, 5'd0, 5'd5, 32'd4, 1'b0), 1'b1,
              mkexp(32'h1000, 7'd19, 32'd4, 6'd5, 1'b0, {32'd0, 32'd10}, {ND, ND}, 8'd1, 1'b0));
    @(negedge clk);
    check("lat_t1", DPRS_en, 1'b0);
    check("head_rs", DPRF_rs, {NR, 6'd1});
    @(negedge clk);
    check("lat_t2", DPRS_en, 1'b1);
    tick(3);

    // back-to-back dependency: add x3 then addi x4,x3
    RoBDP_RoB_index = 8'd7; RFDP_V = {32'd2, 32'd1};
    push_inst(mk(32'h2000, 7'd28, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0), 1'b1,
              mkexp(32'h2000, 7'd28, 32'd0, 6'd3, 1'b0, {32'd2, 32'd1}, {ND, ND}, 8'd7, 1'b0));
    push_inst(mk(32'h2004, 7'd19, 5'd3, 5'd0, 5'd4, 32'd1, 1'b0), 1'b1,
              mkexp(32'h2004, 7'd19, 32'd1, 6'd4, 1'b0, 64'd0, {ND, 9'd7}, 8'd8, 1'b0));
    RoBDP_RoB_index = 8'd8;
    tick(4);

    // CDB priority on j, RoB-ready value on k
    RoBDP_RoB_index = 8'd9; RFDP_Q = {9'd9, 9'd5}; RFDP_V = {32'hAAAA, 32'hBBBB};
    RoBDP_ready = 2'b10; RoBDP_V = {32'h77, 32'h66};
    CDB_en = 2'b11; CDB_RoB_index = {8'd5, 8'd5}; CDB_value = {32'h55, 32'h11};
    push_inst(mk(32'h3000, 7'd29, 5'd1, 5'd2, 5'd6, 32'd0, 1'b1), 1'b1,
              mkexp(32'h3000, 7'd29, 32'd0, 6'd6, 1'b1, {32'h77, 32'h11}, {ND, ND}, 8'd9, 1'b0));
    tick(4);

    // store: CDB channel 1 resolves j, k keeps its tag, rd unused
    RoBDP_RoB_index = 8'd10; RFDP_Q = {9'd4, 9'd3}; RoBDP_ready = 2'b00;
    CDB_en = 2'b10; CDB_RoB_index = {8'd3, 8'd5}; CDB_value = {32'h99, 32'h11};
    push_inst(mk(32'h3004, 7'd16, 5'd2, 5'd1, 5'd7, 32'd8, 1'b0), 1'b1,
              mkexp(32'h3004, 7'd16, 32'd8, NR, 1'b0, {32'd0, 32'h99}, {9'd4, ND}, 8'd10, 1'b1));
    tick(4);
    CDB_en = 2'b00; RFDP_Q = {ND, ND};

    // rdy low holds a queued addi x0 (rd becomes unused)
    RoBDP_RoB_index = 8'd11; RFDP_V = {32'd0, 32'd5};
    push_inst(mk(32'h4000, 7'd19, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0), 1'b1,
              mkexp(32'h4000, 7'd19, 32'd1, NR, 1'b0, {32'd0, 32'd5}, {ND, ND}, 8'd11, 1'b0));
    rdy = 1'b0;
    check_idle("rdy_hold", 3);
    rdy = 1'b1;
    tick(4);

    // LSB back-pressure with four loads, then release in order
    LSB_full = 1'b1; RoBDP_RoB_index = 8'd20; RFDP_V = {32'd0, 32'h100};
    for (int i = 0; i < 4; i++)
      push_inst(mk(32'h5000 + 32'(4*i), 7'd11, 5'd1, 5'd0, 5'(10+i), 32'(i), 1'b0), 1'b1,
                mkexp(32'h5000 + 32'(4*i), 7'd11, 32'(i), 6'(10+i), 1'b0,
                      {32'd0, 32'h100}, {ND, ND}, 8'd20, 1'b1));
    check("full_ready", DPDC_ready, 1'b0);
    check_idle("lsb_hold", 3);
    LSB_full = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lsb_stream", DPLSB_en, 1'b1);
      @(posedge clk);
    end
    tick(3);

    // flush with three queued plus an offer in the flush cycle
    RS_full = 1'b1;
    for (int i = 0; i < 3; i++)
      push_inst(mk(32'h6000 + 32'(4*i), 7'd19, 5'd1, 5'd0, 5'd8, 32'd0, 1'b0), 1'b0, none);
    DCDP_en = 1'b1; DCDP_inst = mk(32'h600C, 7'd19, 5'd1, 5'd0, 5'd9, 32'd0, 1'b0);
    RoBDP_flush = 1'b1;
    tick(1);
    DCDP_en = 1'b0; RoBDP_flush = 1'b0; RS_full = 1'b0;
    check_idle("flush_idle", 6);

    // reset mid-operation with three queued
    RS_full = 1'b1;
    for (int i = 0; i < 3; i++)
      push_inst(mk(32'h7000 + 32'(4*i), 7'd19, 5'd1, 5'd0, 5'd8, 32'd0, 1'b0), 1'b0, none);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; RS_full = 1'b0;
    @(negedge clk);
    check("rst2_ready", DPDC_ready, 1'b1);
    check("rst2_state", {DP_V, DP_Q, DPRF_rd, DPRF_RoB_index}, '0);
    check_idle("rst2_idle", 6);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
